// File: rtl/host_dma_wr_engine.sv
// rtl/host_dma_wr_engine.sv - DMA write engine: descriptor + DW stream to host writes with optional MSI-X
module host_dma_wr_engine #(
    parameter logic [63:0] MSIX_ADDR = 64'h0000_0000_0000_0001,
    parameter logic [31:0] MSIX_DATA = 32'h1234_5678,
    parameter int          LEN_W     = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             desc_valid,
    output logic             desc_ready,
    input  logic [63:0]      desc_addr,
    input  logic [LEN_W-1:0] desc_len,
    input  logic             desc_irq,
    input  logic             wdata_valid,
    output logic             wdata_ready,
    input  logic [31:0]      wdata,
    output logic             hw_valid,
    input  logic             hw_ready,
    output logic [63:0]      hw_addr,
    output logic [31:0]      hw_data,
    output logic             hw_is_msix,
    output logic             busy,
    output logic             done,
    output logic             err_len
);

    typedef enum logic [1:0] {IDLE, DATA, MSIX, FIN} state_t;

    localparam logic [LEN_W-1:0] MAX_LEN = {1'b1, {(LEN_W-1){1'b0}}};

    state_t             state_q, state_d;
    logic               desc_ready_q, desc_ready_d;
    logic               irq_q, irq_d;
    logic [63:0]        cur_addr_q, cur_addr_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic               hw_valid_q, hw_valid_d;
    logic [63:0]        hw_addr_q, hw_addr_d;
    logic [31:0]        hw_data_q, hw_data_d;
    logic               hw_is_msix_q, hw_is_msix_d;
    logic               done_q, done_d;
    logic               err_len_q, err_len_d;

    logic               out_free;
    logic               desc_fire;
    logic               len_bad;

    // The output register can take a new write when empty or draining this cycle.
    assign out_free    = !hw_valid_q || hw_ready;
    assign desc_fire   = desc_valid && desc_ready_q;
    assign len_bad     = (desc_len == '0) || (desc_len > MAX_LEN);
    assign wdata_ready = (state_q == DATA) && out_free;

    always_comb begin
        state_d      = state_q;
        irq_d        = irq_q;
        cur_addr_d   = cur_addr_q;
        rem_d        = rem_q;
        hw_valid_d   = hw_valid_q;
        hw_addr_d    = hw_addr_q;
        hw_data_d    = hw_data_q;
        hw_is_msix_d = hw_is_msix_q;
        done_d       = 1'b0;
        err_len_d    = 1'b0;
        // Held low through the IDLE entry cycle so a new descriptor lands after done.
        desc_ready_d = (state_q == IDLE) && !desc_fire;

        if (hw_valid_q && hw_ready) begin
            hw_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (desc_fire) begin
                    cur_addr_d = desc_addr;
                    irq_d      = desc_irq;
                    rem_d      = desc_len;
                    if (len_bad) begin
                        err_len_d = 1'b1;
                        state_d   = desc_irq ? MSIX : FIN;
                    end else begin
                        state_d   = DATA;
                    end
                end
            end
            DATA: begin
                if (wdata_valid && wdata_ready) begin
                    hw_valid_d   = 1'b1;
                    hw_addr_d    = cur_addr_q;
                    hw_data_d    = wdata;
                    hw_is_msix_d = 1'b0;
                    cur_addr_d   = cur_addr_q + 64'd4;
                    rem_d        = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        state_d = irq_q ? MSIX : FIN;
                    end
                end
            end
            MSIX: begin
                if (out_free) begin
                    hw_valid_d   = 1'b1;
                    hw_addr_d    = MSIX_ADDR;
                    hw_data_d    = MSIX_DATA;
                    hw_is_msix_d = 1'b1;
                    state_d      = FIN;
                end
            end
            FIN: begin
                if (out_free) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            desc_ready_q <= 1'b0;
            irq_q        <= 1'b0;
            cur_addr_q   <= '0;
            rem_q        <= '0;
            hw_valid_q   <= 1'b0;
            hw_addr_q    <= '0;
            hw_data_q    <= '0;
            hw_is_msix_q <= 1'b0;
            done_q       <= 1'b0;
            err_len_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            desc_ready_q <= desc_ready_d;
            irq_q        <= irq_d;
            cur_addr_q   <= cur_addr_d;
            rem_q        <= rem_d;
            hw_valid_q   <= hw_valid_d;
            hw_addr_q    <= hw_addr_d;
            hw_data_q    <= hw_data_d;
            hw_is_msix_q <= hw_is_msix_d;
            done_q       <= done_d;
            err_len_q    <= err_len_d;
        end
    end

    assign desc_ready = desc_ready_q;
    assign hw_valid   = hw_valid_q;
    assign hw_addr    = hw_addr_q;
    assign hw_data    = hw_data_q;
    assign hw_is_msix = hw_is_msix_q;
    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign err_len    = err_len_q;

endmodule

// File: tb/tb_host_dma_wr_engine.sv
// tb/tb_host_dma_wr_engine.sv - randomized self-checking bench for host_dma_wr_engine
module tb_host_dma_wr_engine;

    localparam logic [63:0] M_ADDR = 64'h0000_0000_0000_0001;
    localparam logic [31:0] M_DATA = 32'h1234_5678;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        desc_valid;
    logic        desc_ready;
    logic [63:0] desc_addr;
    logic [8:0]  desc_len;
    logic        desc_irq;
    logic        wdata_valid;
    logic        wdata_ready;
    logic [31:0] wdata;
    logic        hw_valid;
    logic        hw_ready;
    logic [63:0] hw_addr;
    logic [31:0] hw_data;
    logic        hw_is_msix;
    logic        busy;
    logic        done;
    logic        err_len;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    host_dma_wr_engine #(
        .MSIX_ADDR (M_ADDR),
        .MSIX_DATA (M_DATA),
        .LEN_W     (9)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .desc_valid  (desc_valid),
        .desc_ready  (desc_ready),
        .desc_addr   (desc_addr),
        .desc_len    (desc_len),
        .desc_irq    (desc_irq),
        .wdata_valid (wdata_valid),
        .wdata_ready (wdata_ready),
        .wdata       (wdata),
        .hw_valid    (hw_valid),
        .hw_ready    (hw_ready),
        .hw_addr     (hw_addr),
        .hw_data     (hw_data),
        .hw_is_msix  (hw_is_msix),
        .busy        (busy),
        .done        (done),
        .err_len     (err_len)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic offer_desc(input logic [63:0] addr, input int len, input bit irq);
        int w;
        @(negedge clk);
        desc_valid  = 1'b1;
        desc_addr   = addr;
        desc_len    = 9'(len);
        desc_irq    = irq;
        wdata_valid = 1'b0;
        hw_ready    = 1'b1;
        w = 0;
        #1;
        while (!desc_ready && w < 50) begin
            @(negedge clk);
            #1;
            w++;
        end
        chk("desc_accept", 64'(desc_ready), 64'd1);
        @(negedge clk);
        desc_valid = 1'b0;
    endtask

    // Reference: descriptor expands to len sequential DW writes (64-bit wrap) plus an optional MSI-X write.
    task automatic run_desc(input logic [63:0] addr, input int len, input bit irq,
                            input int stall_pct, input int vpct, input logic [31:0] dbase);
        logic [63:0] ea[$];
        logic [31:0] ed[$];
        bit          em[$];
        logic [31:0] words[$];
        int          bc[$];
        bit          good, pend, seen_done;
        int          n, widx, consumed, hidx, nerr, extra_hw, cyc;
        logic [63:0] pa;
        logic [31:0] pd;
        logic        pm;

        good = (len >= 1) && (len <= 256);
        n    = good ? len : 0;
        for (int i = 0; i < n; i++) begin
            words.push_back((dbase != 32'd0) ? dbase + 32'(i) : $urandom);
            ea.push_back(addr + 64'(4 * i));
            ed.push_back(words[i]);
            em.push_back(1'b0);
        end
        if (irq) begin
            ea.push_back(M_ADDR);
            ed.push_back(M_DATA);
            em.push_back(1'b1);
        end

        offer_desc(addr, len, irq);

        widx = 0; consumed = 0; hidx = 0; nerr = 0; extra_hw = 0;
        pend = 1'b0; seen_done = 1'b0; pa = '0; pd = '0; pm = 1'b0;
        for (cyc = 0; cyc < 4000 && !seen_done; cyc++) begin
            hw_ready    = ($urandom_range(0, 99) >= stall_pct);
            wdata_valid = ($urandom_range(0, 99) < vpct);
            wdata       = (widx < n) ? words[widx] : $urandom;
            #1;
            if (pend) begin
                chk("hold_valid", 64'(hw_valid), 64'd1);
                chk("hold_addr", hw_addr, pa);
                chk("hold_data", 64'(hw_data), 64'(pd));
                chk("hold_msix", 64'(hw_is_msix), 64'(pm));
                if (!hw_ready) chk("stall_wready", 64'(wdata_ready), 64'd0);
            end
            if (err_len) begin
                nerr++;
                chk("err_len_cycle", 64'(cyc), 64'd0);
            end
            if (wdata_valid && wdata_ready) begin
                consumed++;
                if (widx < n) begin
                    bc.push_back(cyc);
                    widx++;
                end
            end
            if (hw_valid && hw_ready) begin
                if (ea.size() == 0) begin
                    extra_hw++;
                end else begin
                    chk("hw_addr", hw_addr, ea[0]);
                    chk("hw_data", 64'(hw_data), 64'(ed[0]));
                    chk("hw_is_msix", 64'(hw_is_msix), 64'(em[0]));
                    if (stall_pct == 0 && !em[0] && hidx < bc.size())
                        chk("latency", 64'(cyc), 64'(bc[hidx] + 1));
                    if (!em[0]) hidx++;
                    void'(ea.pop_front());
                    void'(ed.pop_front());
                    void'(em.pop_front());
                end
            end
            pend = hw_valid && !hw_ready;
            pa = hw_addr; pd = hw_data; pm = hw_is_msix;
            if (done) seen_done = 1'b1;
            @(negedge clk);
        end
        wdata_valid = 1'b0;
        hw_ready    = 1'b1;
        #1;
        chk("done_seen", 64'(seen_done), 64'd1);
        chk("done_single", 64'(done), 64'd0);
        chk("busy_after", 64'(busy), 64'd0);
        chk("desc_ready_after", 64'(desc_ready), 64'd1);
        chk("writes_left", 64'(ea.size()), 64'd0);
        chk("extra_hw", 64'(extra_hw), 64'd0);
        chk("beats", 64'(consumed), 64'(n));
        chk("err_cnt", 64'(nerr), good ? 64'd0 : 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nhs;
        rst_n = 1'b0; desc_valid = 1'b0; desc_addr = '0; desc_len = '0; desc_irq = 1'b0;
        wdata_valid = 1'b0; wdata = '0; hw_ready = 1'b0;
        @(negedge clk); @(negedge clk);
        #1;
        chk("rst_desc_ready", 64'(desc_ready), 64'd0);
        chk("rst_hw_valid", 64'(hw_valid), 64'd0);
        chk("rst_hw_addr", hw_addr, 64'd0);
        chk("rst_busy_done_err", {61'd0, busy, done, err_len}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("desc_ready_post_rst", 64'(desc_ready), 64'd1);

        run_desc(64'h1000, 4, 1'b0, 0, 100, 32'hA0);
        run_desc(64'h2000, 1, 1'b1, 0, 100, 32'hDEADBEEF);
        run_desc(64'h3000, 3, 1'b0, 60, 100, 32'd0);
        run_desc(64'hFFFF_FFFF_FFFF_FFFC, 2, 1'b0, 0, 100, 32'd0);
        run_desc(64'h4000, 0, 1'b1, 0, 100, 32'd0);
        run_desc(64'h4000, 257, 1'b0, 0, 100, 32'd0);
        run_desc(64'h8000, 256, 1'b1, 30, 70, 32'd0);

        offer_desc(64'h5000, 8, 1'b1);
        hw_ready = 1'b1; wdata_valid = 1'b1; wdata = $urandom;
        nhs = 0;
        for (int i = 0; i < 50 && nhs < 3; i++) begin
            #1;
            if (hw_valid && hw_ready) nhs++;
            if (nhs < 3) @(negedge clk);
        end
        chk("pre_rst_writes", 64'(nhs), 64'd3);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_hw", {hw_addr[63:2], hw_valid, hw_is_msix}, 64'd0);
        chk("midrst_data", {30'd0, hw_addr[1:0], hw_data}, 64'd0);
        chk("midrst_flags", {59'd0, busy, done, err_len, desc_ready, wdata_ready}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1; wdata_valid = 1'b0;
        #1;
        chk("post_rst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        #1;
        chk("post_rst_desc_ready", 64'(desc_ready), 64'd1);
        run_desc(64'h6000, 2, 1'b0, 0, 100, 32'd0);

        for (int k = 0; k < 8; k++) begin
            run_desc({$urandom, $urandom} & ~64'd3, $urandom_range(0, 300), 1'($urandom),
                     $urandom_range(0, 70), $urandom_range(30, 100), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
